// File: rtl/divider_controller.sv
// divider_controller
//   Operator-interface sequencer for a 16-by-8 unsigned restoring divider.
//   Button pulses edit the operands nibble by nibble, START runs a one-cycle
//   operand check followed by ITER restoring-division steps, and the result
//   is presented in SHOW. All outputs come straight from registers.
//
// Ports
//   CLK          system clock, everything on posedge
//   RST          synchronous active-high reset
//   BTN_START    pulse: launch a division (from EDIT_DVD, EDIT_DVS, SHOW)
//   BTN_FIELD    pulse: toggle the field being edited / viewed
//   BTN_DIGIT    pulse: advance the selected nibble
//   BTN_INC      pulse: increment the selected nibble (in SHOW: back to edit)
//   DIVIDEND     edited 16-bit dividend
//   DIVISOR      edited 8-bit divisor
//   QUOTIENT     8-bit quotient
//   REMAINDER    8-bit remainder
//   DZ/DO/OPERR  divide-by-zero, overflow, operation-error flags
//   DATA_SELECT  display field: 00 dvd, 01 dvs, 10 quotient, 11 remainder
//   BIT_SELECT   nibble index within the displayed field
//   BUSY         high during CHECK and RUN
//   DONE         one-cycle pulse on entry to SHOW
//
// Button protocol: each BTN_* is a pre-debounced pulse that is high for
// exactly one CLK cycle and is consumed on the edge that samples it; there
// is no back-pressure. When several are high together only the highest
// priority one (START > FIELD > DIGIT > INC) acts. While BUSY, any pulse
// only sets OPERR.
module divider_controller #(
  parameter int ITER = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BTN_START,
  input  logic        BTN_FIELD,
  input  logic        BTN_DIGIT,
  input  logic        BTN_INC,
  output logic [15:0] DIVIDEND,
  output logic [7:0]  DIVISOR,
  output logic [7:0]  QUOTIENT,
  output logic [7:0]  REMAINDER,
  output logic        DZ,
  output logic        DO,
  output logic        OPERR,
  output logic [1:0]  DATA_SELECT,
  output logic [1:0]  BIT_SELECT,
  output logic        BUSY,
  output logic        DONE
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST_STEP = CW'(ITER - 1);

  typedef enum logic [2:0] {
    S_EDIT_DVD = 3'd0,
    S_EDIT_DVS = 3'd1,
    S_CHECK    = 3'd2,
    S_RUN      = 3'd3,
    S_SHOW     = 3'd4
  } state_t;

  state_t         r_state;
  logic [15:0]    r_dividend;
  logic [7:0]     r_divisor;
  logic [7:0]     r_quot;
  logic [7:0]     r_rem;
  logic           r_dz;
  logic           r_do;
  logic           r_operr;
  logic [1:0]     r_dsel;
  logic [1:0]     r_bsel;
  logic           r_busy;
  logic           r_done;
  // Partial remainder is kept at 8 bits: it is always below DIVISOR.
  logic [7:0]     r_p;
  logic [7:0]     r_s;
  logic [7:0]     r_q;
  logic [CW-1:0]  r_cnt;

  logic           w_any_btn;
  logic           w_idle;
  logic [8:0]     w_trial;
  logic           w_ge;
  logic [7:0]     w_p_next;
  logic [7:0]     w_q_next;
  logic [15:0]    w_dvd_inc;
  logic [7:0]     w_dvs_inc;

  assign w_any_btn = BTN_START | BTN_FIELD | BTN_DIGIT | BTN_INC;
  assign w_idle    = (r_state == S_EDIT_DVD) || (r_state == S_EDIT_DVS) ||
                     (r_state == S_SHOW);

  // One restoring step. When the trial value is >= divisor the true
  // difference is below the divisor, so an 8-bit subtraction is exact.
  assign w_trial  = {r_p, r_s[7]};
  assign w_ge     = (w_trial >= {1'b0, r_divisor});
  assign w_p_next = w_ge ? (w_trial[7:0] - r_divisor) : w_trial[7:0];
  assign w_q_next = {r_q[6:0], w_ge};

  // Nibble increment without carry into the neighbouring nibble.
  always_comb begin
    w_dvd_inc = r_dividend;
    case (r_bsel)
      2'd0:    w_dvd_inc[3:0]   = r_dividend[3:0]   + 4'd1;
      2'd1:    w_dvd_inc[7:4]   = r_dividend[7:4]   + 4'd1;
      2'd2:    w_dvd_inc[11:8]  = r_dividend[11:8]  + 4'd1;
      default: w_dvd_inc[15:12] = r_dividend[15:12] + 4'd1;
    endcase
  end

  always_comb begin
    w_dvs_inc = r_divisor;
    if (r_bsel[0]) w_dvs_inc[7:4] = r_divisor[7:4] + 4'd1;
    else           w_dvs_inc[3:0] = r_divisor[3:0] + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_EDIT_DVD;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dz       <= 1'b0;
      r_do       <= 1'b0;
      r_operr    <= 1'b0;
      r_dsel     <= 2'b00;
      r_bsel     <= 2'b00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_p        <= '0;
      r_s        <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_idle && BTN_START) begin
        r_quot  <= '0;
        r_rem   <= '0;
        r_dz    <= 1'b0;
        r_do    <= 1'b0;
        r_operr <= 1'b0;
        r_busy  <= 1'b1;
        r_state <= S_CHECK;
      end else begin
        case (r_state)
          S_EDIT_DVD: begin
            if (BTN_FIELD) begin
              r_state <= S_EDIT_DVS;
              r_dsel  <= 2'b01;
              r_bsel  <= 2'b00;
            end else if (BTN_DIGIT) begin
              r_bsel <= r_bsel + 2'd1;
            end else if (BTN_INC) begin
              r_dividend <= w_dvd_inc;
            end
          end
          S_EDIT_DVS: begin
            if (BTN_FIELD) begin
              r_state <= S_EDIT_DVD;
              r_dsel  <= 2'b00;
              r_bsel  <= 2'b00;
            end else if (BTN_DIGIT) begin
              r_bsel <= {1'b0, ~r_bsel[0]};
            end else if (BTN_INC) begin
              r_divisor <= w_dvs_inc;
            end
          end
          S_CHECK: begin
            if (w_any_btn) r_operr <= 1'b1;
            if (r_divisor == 8'd0) begin
              r_dz    <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_dsel  <= 2'b10;
              r_bsel  <= 2'b00;
              r_state <= S_SHOW;
            end else if (r_dividend[15:8] >= r_divisor) begin
              // Quotient would not fit in 8 bits.
              r_do    <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_dsel  <= 2'b10;
              r_bsel  <= 2'b00;
              r_state <= S_SHOW;
            end else begin
              r_p     <= r_dividend[15:8];
              r_s     <= r_dividend[7:0];
              r_q     <= '0;
              r_cnt   <= '0;
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            if (w_any_btn) r_operr <= 1'b1;
            r_p   <= w_p_next;
            r_s   <= {r_s[6:0], 1'b0};
            r_q   <= w_q_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_STEP) begin
              r_quot  <= w_q_next;
              r_rem   <= w_p_next;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_dsel  <= 2'b10;
              r_bsel  <= 2'b00;
              r_state <= S_SHOW;
            end
          end
          S_SHOW: begin
            if (BTN_FIELD) begin
              r_dsel <= {1'b1, ~r_dsel[0]};
            end else if (BTN_DIGIT) begin
              r_dsel <= r_dsel;  // DIGIT has no effect here but still masks INC
            end else if (BTN_INC) begin
              r_state <= S_EDIT_DVD;
              r_dsel  <= 2'b00;
              r_bsel  <= 2'b00;
            end
          end
          default: begin
            r_state <= S_EDIT_DVD;
            r_dsel  <= 2'b00;
            r_bsel  <= 2'b00;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign DIVIDEND    = r_dividend;
  assign DIVISOR     = r_divisor;
  assign QUOTIENT    = r_quot;
  assign REMAINDER   = r_rem;
  assign DZ          = r_dz;
  assign DO          = r_do;
  assign OPERR       = r_operr;
  assign DATA_SELECT = r_dsel;
  assign BIT_SELECT  = r_bsel;
  assign BUSY        = r_busy;
  assign DONE        = r_done;

endmodule

// File: tb/tb_divider_controller.sv
// tb_divider_controller
//   Bench for divider_controller. A behavioural model (plain arithmetic
//   division, a busy-cycle countdown and field/nibble bookkeeping) tracks
//   every output and is compared against the DUT on each falling edge.
//   Directed sequences pin the model with literal expectations; a random
//   phase follows.
module tb_divider_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        BTN_START = 1'b0;
  logic        BTN_FIELD = 1'b0;
  logic        BTN_DIGIT = 1'b0;
  logic        BTN_INC = 1'b0;
  logic [15:0] DIVIDEND;
  logic [7:0]  DIVISOR;
  logic [7:0]  QUOTIENT;
  logic [7:0]  REMAINDER;
  logic        DZ;
  logic        DO;
  logic        OPERR;
  logic [1:0]  DATA_SELECT;
  logic [1:0]  BIT_SELECT;
  logic        BUSY;
  logic        DONE;

  divider_controller #(.ITER(8)) dut (
    .CLK(CLK), .RST(RST),
    .BTN_START(BTN_START), .BTN_FIELD(BTN_FIELD),
    .BTN_DIGIT(BTN_DIGIT), .BTN_INC(BTN_INC),
    .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
    .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER),
    .DZ(DZ), .DO(DO), .OPERR(OPERR),
    .DATA_SELECT(DATA_SELECT), .BIT_SELECT(BIT_SELECT),
    .BUSY(BUSY), .DONE(DONE)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_DVD  = 0;
  localparam int M_DVS  = 1;
  localparam int M_BUSY = 2;
  localparam int M_SHOW = 3;

  int          m_mode;
  int          m_left;
  int unsigned m_dvd, m_dvs, m_q, m_r, m_dsel, m_bsel;
  int unsigned p_q, p_r;
  bit          m_dz, m_do, m_operr, m_busy, m_done, p_dz, p_do;
  bit          m_valid = 1'b0;

  // Results are decided up front with ordinary division; the busy phase
  // is just a countdown of 1 (rejected operands) or 1+8 (full run) edges.
  task automatic model_start();
    m_q = 0; m_r = 0; m_dz = 0; m_do = 0; m_operr = 0;
    m_busy = 1; m_mode = M_BUSY;
    p_q = 0; p_r = 0; p_dz = 0; p_do = 0;
    if (m_dvs == 0) begin
      p_dz = 1; m_left = 1;
    end else if ((m_dvd / 256) >= m_dvs) begin
      p_do = 1; m_left = 1;
    end else begin
      p_q = m_dvd / m_dvs; p_r = m_dvd % m_dvs; m_left = 1 + 8;
    end
  endtask

  function automatic int unsigned nib_inc(input int unsigned v, input int unsigned idx);
    int unsigned n;
    n = (v >> (4 * idx)) & 15;
    n = (n + 1) % 16;
    return (v & ~(32'd15 << (4 * idx))) | (n << (4 * idx));
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_valid = 1; m_mode = M_DVD; m_left = 0;
      m_dvd = 0; m_dvs = 0; m_q = 0; m_r = 0; m_dsel = 0; m_bsel = 0;
      m_dz = 0; m_do = 0; m_operr = 0; m_busy = 0; m_done = 0;
    end else if (m_valid) begin
      m_done = 0;
      if (m_mode == M_BUSY) begin
        if (BTN_START | BTN_FIELD | BTN_DIGIT | BTN_INC) m_operr = 1;
        m_left--;
        if (m_left == 0) begin
          m_mode = M_SHOW; m_q = p_q; m_r = p_r; m_dz = p_dz; m_do = p_do;
          m_busy = 0; m_done = 1; m_dsel = 2; m_bsel = 0;
        end
      end else if (BTN_START) begin
        model_start();
      end else if (m_mode == M_DVD) begin
        if (BTN_FIELD) begin m_mode = M_DVS; m_dsel = 1; m_bsel = 0; end
        else if (BTN_DIGIT) m_bsel = (m_bsel + 1) % 4;
        else if (BTN_INC) m_dvd = nib_inc(m_dvd, m_bsel);
      end else if (m_mode == M_DVS) begin
        if (BTN_FIELD) begin m_mode = M_DVD; m_dsel = 0; m_bsel = 0; end
        else if (BTN_DIGIT) m_bsel = (m_bsel == 0) ? 1 : 0;
        else if (BTN_INC) m_dvs = nib_inc(m_dvs, m_bsel);
      end else begin
        if (BTN_FIELD) m_dsel = (m_dsel == 2) ? 3 : 2;
        else if (BTN_DIGIT) m_dsel = m_dsel;
        else if (BTN_INC) begin m_mode = M_DVD; m_dsel = 0; m_bsel = 0; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (m_valid) begin
      check("dividend",    DIVIDEND,    m_dvd);
      check("divisor",     DIVISOR,     m_dvs);
      check("quotient",    QUOTIENT,    m_q);
      check("remainder",   REMAINDER,   m_r);
      check("dz",          DZ,          m_dz);
      check("do",          DO,          m_do);
      check("operr",       OPERR,       m_operr);
      check("data_select", DATA_SELECT, m_dsel);
      check("bit_select",  BIT_SELECT,  m_bsel);
      check("busy",        BUSY,        m_busy);
      check("done",        DONE,        m_done);
    end
  end

  // ---------------- driver tasks ----------------
  localparam logic [3:0] B_START = 4'b1000;
  localparam logic [3:0] B_FIELD = 4'b0100;
  localparam logic [3:0] B_DIGIT = 4'b0010;
  localparam logic [3:0] B_INC   = 4'b0001;

  task automatic pulse(input logic [3:0] m);
    @(negedge CLK); #1;
    {BTN_START, BTN_FIELD, BTN_DIGIT, BTN_INC} = m;
    @(negedge CLK); #1;
    {BTN_START, BTN_FIELD, BTN_DIGIT, BTN_INC} = 4'b0000;
  endtask

  task automatic pulse_n(input logic [3:0] m, input int n);
    for (int i = 0; i < n; i++) pulse(m);
  endtask

  task automatic do_reset();
    @(negedge CLK); #1 RST = 1'b1;
    @(negedge CLK); #1 RST = 1'b0;
  endtask

  // From the reset state: write both operands, ends in EDIT_DVS nibble 0.
  task automatic set_operands(input int unsigned dvd, input int unsigned dvs);
    for (int i = 0; i < 4; i++) begin
      pulse_n(B_INC, (dvd >> (4 * i)) & 15);
      pulse(B_DIGIT);
    end
    pulse(B_FIELD);
    for (int i = 0; i < 2; i++) begin
      pulse_n(B_INC, (dvs >> (4 * i)) & 15);
      pulse(B_DIGIT);
    end
  endtask

  // Call right after the START pulse returns (sample 1 of the operation);
  // returns the sample index on which DONE was seen.
  task automatic wait_done(input string name, output int lat);
    lat = 1;
    while (!DONE && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    if (!DONE) check({name, "_done_timeout"}, 0, 1);
  endtask

  // ---------------- stimulus ----------------
  int lat;
  int done_cnt;

  initial begin
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;

    // Reset state pinned by literals
    check("rst_dividend", DIVIDEND, 0);
    check("rst_dsel", DATA_SELECT, 0);
    check("rst_busy", BUSY, 0);

    // 1: 0x0064 / 0x07 = 0x0E rem 0x02
    set_operands('h0064, 'h07);
    pulse(B_START);
    check("t1_busy_first", BUSY, 1);
    wait_done("t1", lat);
    check("t1_latency", lat, 10);
    check("t1_quot", QUOTIENT, 'h0E);
    check("t1_rem", REMAINDER, 'h02);
    check("t1_dsel", DATA_SELECT, 2);
    check("t1_flags", {DZ, DO, OPERR}, 0);

    // 2: divide by zero, overflow, then 0x1234 / 0x13
    do_reset();
    set_operands('h1234, 'h00);
    pulse(B_START);
    wait_done("t2dz", lat);
    check("t2_dz_latency", lat, 2);
    check("t2_dz", DZ, 1);
    check("t2_dz_do", DO, 0);
    check("t2_dz_quot", QUOTIENT, 0);
    pulse(B_INC);
    pulse(B_FIELD);
    pulse_n(B_INC, 2);
    pulse(B_DIGIT);
    pulse(B_INC);
    pulse(B_DIGIT);
    check("t2_divisor", DIVISOR, 'h12);
    pulse(B_START);
    wait_done("t2do", lat);
    check("t2_do", DO, 1);
    check("t2_do_dz", DZ, 0);
    pulse(B_INC);
    pulse(B_FIELD);
    pulse(B_INC);
    pulse(B_START);
    wait_done("t2div", lat);
    check("t2_latency", lat, 10);
    check("t2_quot", QUOTIENT, 'hF5);
    check("t2_rem", REMAINDER, 'h05);

    // 6: SHOW field toggling and return to edit
    pulse(B_FIELD);
    check("t6_dsel_rem", DATA_SELECT, 3);
    pulse(B_FIELD);
    check("t6_dsel_quot", DATA_SELECT, 2);
    pulse(B_DIGIT);
    check("t6_digit_ignored", BIT_SELECT, 0);
    pulse(B_INC);
    check("t6_dsel_edit", DATA_SELECT, 0);
    check("t6_quot_held", QUOTIENT, 'hF5);

    // 3: editing wrap
    do_reset();
    pulse_n(B_DIGIT, 4);
    check("t3_bsel_wrap", BIT_SELECT, 0);
    pulse_n(B_DIGIT, 2);
    pulse_n(B_INC, 15);
    check("t3_dvd_0f00", DIVIDEND, 'h0F00);
    pulse_n(B_INC, 16);
    check("t3_dvd_wrap", DIVIDEND, 'h0F00);
    pulse(B_FIELD);
    check("t3_dvs_bsel0", BIT_SELECT, 0);
    pulse(B_DIGIT);
    check("t3_dvs_bsel1", BIT_SELECT, 1);
    pulse(B_DIGIT);
    check("t3_dvs_bsel2", BIT_SELECT, 0);

    // 4: START beats INC; a pulse while running sets OPERR only
    do_reset();
    set_operands('h0064, 'h07);
    pulse(B_FIELD);
    pulse(B_START | B_INC);
    check("t4_busy", BUSY, 1);
    check("t4_dvd_kept", DIVIDEND, 'h0064);
    pulse(B_DIGIT);
    wait_done("t4", lat);
    check("t4_operr", OPERR, 1);
    check("t4_quot", QUOTIENT, 'h0E);
    check("t4_rem", REMAINDER, 'h02);
    pulse(B_START);
    check("t4_operr_clr", OPERR, 0);
    wait_done("t4b", lat);

    // 5: reset during RUN
    pulse(B_START);
    repeat (3) @(negedge CLK);
    do_reset();
    check("t5_dvd", DIVIDEND, 0);
    check("t5_busy", BUSY, 0);
    check("t5_dsel", DATA_SELECT, 0);
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (DONE) done_cnt++;
    end
    check("t5_no_done", done_cnt, 0);

    // Random phase
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK); #1;
      BTN_START = ($urandom_range(0, 7) == 0);
      BTN_FIELD = ($urandom_range(0, 5) == 0);
      BTN_DIGIT = ($urandom_range(0, 4) == 0);
      BTN_INC   = ($urandom_range(0, 2) == 0);
      RST       = ($urandom_range(0, 399) == 0);
    end
    @(negedge CLK); #1;
    {BTN_START, BTN_FIELD, BTN_DIGIT, BTN_INC} = 4'b0000;
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/divider_controller.md
Name: divider_controller

Overview:
Sequencer and operator-interface controller for the 16-by-8 unsigned divider project on the Spartan-3 board. It turns pre-debounced single-cycle button pulses into operand editing and runs an 8-step restoring division. It sets the divide-by-zero, overflow and operation-error flags. It drives the data-select and nibble-select codes consumed by the 7-segment display driver. All results and flags are registered outputs.

Parameters:
ITER, 8, number of restoring-division steps (quotient width); fixed at 8 for this design.

Ports:
CLK  input  1  system clock. Single clock domain; all logic on posedge CLK.
RST  input  1  reset, synchronous, active-high.
BTN_START  input  1  one-cycle pulse; launch a division.
BTN_FIELD  input  1  one-cycle pulse; toggle the field being edited or viewed.
BTN_DIGIT  input  1  one-cycle pulse; advance the selected nibble.
BTN_INC  input  1  one-cycle pulse; increment the selected nibble.
DIVIDEND  output  16  edited dividend.
DIVISOR  output  8  edited divisor.
QUOTIENT  output  8  result quotient.
REMAINDER  output  8  result remainder.
DZ  output  1  divide-by-zero flag.
DO  output  1  divider-overflow flag.
OPERR  output  1  operation-input error flag.
DATA_SELECT  output  2  field code: 00 dividend, 01 divisor, 10 quotient, 11 remainder.
BIT_SELECT  output  2  nibble index within the selected field.
BUSY  output  1  high while in CHECK or RUN.
DONE  output  1  one-cycle pulse on entry to SHOW.

Behaviour:
- Reset (RST=1 at posedge): every output goes to 0 and the state goes to EDIT_DVD. Reset overrides everything, including a division in progress; a partial result is discarded.
- Button priority when pulses coincide: START > FIELD > DIGIT > INC. Only the highest-priority pulse acts in a cycle.
- EDIT_DVD: DATA_SELECT=00.
  - DIGIT: BIT_SELECT advances 0→1→2→3→0.
  - INC: the selected dividend nibble increments modulo 16; no carry into the next nibble.
  - FIELD: go to EDIT_DVS with BIT_SELECT=0.
- EDIT_DVS: DATA_SELECT=01.
  - DIGIT: BIT_SELECT toggles between 0 and 1 only.
  - INC: the selected divisor nibble increments modulo 16.
  - FIELD: go to EDIT_DVD with BIT_SELECT=0.
- START from EDIT_DVD, EDIT_DVS or SHOW: clear QUOTIENT, REMAINDER, DZ, DO and OPERR; set BUSY=1; go to CHECK. DATA_SELECT and BIT_SELECT hold their values.
- CHECK (1 cycle), evaluated in this order:
  - DIVISOR==0: DZ=1, go to SHOW.
  - Else DIVIDEND[15:8] >= DIVISOR: DO=1, go to SHOW.
  - Else: load the 9-bit partial remainder P={1'b0, DIVIDEND[15:8]}, load the shift register S=DIVIDEND[7:0], clear the step counter, go to RUN.
- RUN: one quotient bit per cycle, MSB first, for exactly ITER cycles.
  - T={P[7:0], S[7]} (9 bits); shift S left by one.
  - If T >= {1'b0, DIVISOR}: P=T-DIVISOR and the quotient bit is 1.
  - Otherwise P=T and the quotient bit is 0.
  - After step 8: QUOTIENT holds the 8 quotient bits, REMAINDER=P[7:0], go to SHOW.
  - Invariant: P < DIVISOR after every step, so REMAINDER < DIVISOR.
- Latency: START sampled at edge t; CHECK at t+1; RUN at t+2..t+9; SHOW entered at t+10 with DONE=1 for that cycle. On the DZ/DO early exit, SHOW is entered at t+2.
- Any entry to SHOW: BUSY=0, DATA_SELECT=10, BIT_SELECT=0.
- SHOW:
  - FIELD toggles DATA_SELECT between 10 and 11.
  - DIGIT is ignored.
  - INC returns to EDIT_DVD with BIT_SELECT=0. Operands are kept; results and flags are held until the next START.
- OPERR: any button pulse during CHECK or RUN sets OPERR=1 and is otherwise ignored. This includes START, so no restart occurs. OPERR stays set until the next accepted START or reset.
- DATA_SELECT is never 10 or 11 in the edit states; no invalid code combination is ever produced.

Test Plan:
1. Reset, then edit DIVIDEND=0x0064 and DIVISOR=0x07, then START at t -> BUSY=1 during t+1..t+9; DONE pulse at t+10; QUOTIENT=0x0E, REMAINDER=0x02, DZ=DO=OPERR=0, DATA_SELECT=10.
2. DIVIDEND=0x1234, DIVISOR=0x00, START -> SHOW at t+2, DZ=1, DO=0, QUOTIENT=REMAINDER=0x00. Then DIVISOR=0x12 and START -> DO=1, DZ=0 (0x12 >= 0x12). Then DIVISOR=0x13 -> QUOTIENT=0xF5, REMAINDER=0x05 (0x1234 = 0x13·0xF5 + 0x05).
3. Editing wrap: in EDIT_DVD, 4 DIGIT pulses return BIT_SELECT to 0; 16 INC pulses on nibble 2 of 0x0F00 return it to 0x0F00 with the other nibbles unchanged. In EDIT_DVS, DIGIT sequence gives BIT_SELECT 0,1,0.
4. BTN_INC and BTN_START asserted in the same cycle while in EDIT_DVD -> only START acts (CHECK next cycle, DIVIDEND unchanged). BTN_DIGIT pulse at t+5 -> OPERR=1, division still completes correctly, OPERR cleared by the next START.
5. RST asserted at t+4 during RUN -> next cycle all outputs are 0, state is EDIT_DVD, and no DONE pulse follows.
6. In SHOW, FIELD -> DATA_SELECT=11; FIELD again -> 10; INC -> EDIT_DVD with DATA_SELECT=00 and QUOTIENT and the flags held.
